// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and a
// majority-vote helper. The transmitter imports the same package.
package uart_pkg;

  // Receiver/transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  localparam int UART_DATA_BITS          = 8;

  // Two-out-of-three majority of a vote register.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle between the board RX pin and the consumer.
//
// Handshake: RX_STATUS and RX_ERR are valid-only strobes, each high for
// exactly one clk cycle and never together. There is no ready: a consumer
// must capture RX_DATA in the cycle RX_STATUS is high or the byte is lost.
// RX_DATA holds the last good byte between strobes.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                      UART_RX;
  logic [UART_DATA_BITS-1:0] RX_DATA;
  logic                      RX_STATUS;
  logic                      RX_ERR;
  logic                      RX_BUSY;
  uart_state_t               state;

  // Pin/consumer side: drives the serial line, observes the results.
  modport master (
    output UART_RX,
    input  RX_DATA,
    input  RX_STATUS,
    input  RX_ERR,
    input  RX_BUSY,
    input  state
  );

  // Receiver side.
  modport slave (
    input  UART_RX,
    output RX_DATA,
    output RX_STATUS,
    output RX_ERR,
    output RX_BUSY,
    output state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input. The reset value is a
// parameter so an idle-high line comes out of reset already idle.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;
  logic sync;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. clk runs at OVERSAMPLE x baud. Each bit is decided by
// a 2-of-3 vote of samples taken around mid-bit; the stop bit is decided at
// mid-bit so a back-to-back start bit is never missed.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int HALF  = OVERSAMPLE / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] VOTE_LO  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] VOTE_MID = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] VOTE_HI  = CNT_W'(HALF + 1);

  logic rx_s;

  uart_state_t               state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [2:0]                bitn, bitn_n;
  logic [2:0]                vote, vote_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [UART_DATA_BITS-1:0] data_q, data_n;
  logic                      status_q, status_n;
  logic                      err_q, err_n;
  logic                      armed, armed_n;
  logic                      in_window;
  logic                      bit_v;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.UART_RX),
    .q     (rx_s)
  );

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bitn     <= '0;
      vote     <= '0;
      shreg    <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      err_q    <= 1'b0;
      armed    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bitn     <= bitn_n;
      vote     <= vote_n;
      shreg    <= shreg_n;
      data_q   <= data_n;
      status_q <= status_n;
      err_q    <= err_n;
      armed    <= armed_n;
    end
  end

  // Vote window sampling: the bit value includes the sample taken this
  // cycle so the stop decision at the last window slot sees all three.
  always_comb begin
    in_window = (cnt == VOTE_LO) || (cnt == VOTE_MID) || (cnt == VOTE_HI);
    vote_n    = in_window ? {vote[1:0], rx_s} : vote;
    bit_v     = majority3(vote_n);
  end

  // Next-state logic, counters, shift register and output strobes.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    shreg_n  = shreg;
    data_n   = data_q;
    status_n = 1'b0;
    err_n    = 1'b0;
    // Any idle-level sample re-arms start detection.
    armed_n  = armed | rx_s;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s && armed) begin
          state_n = ST_START;
        end
      end

      ST_START: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_v) begin
            // Start bit did not hold low through mid-bit: a glitch.
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            bitn_n  = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {bit_v, shreg[UART_DATA_BITS-1:1]};
          if (bitn == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            bitn_n = bitn + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt == VOTE_HI) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (bit_v) begin
            data_n   = shreg;
            status_n = 1'b1;
          end else begin
            // Framing error; disarm so a held-low break cannot retrigger.
            err_n   = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.RX_DATA   = data_q;
  assign bus.RX_STATUS = status_q;
  assign bus.RX_ERR    = err_q;
  assign bus.RX_BUSY   = (state != ST_IDLE);
  assign bus.state     = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at OVERSAMPLE = 16.
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS     = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = OS * CLK_NS;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_receiver_if bus();

  uart_receiver #(
    .OVERSAMPLE (OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Count of rising edges seen so far; stable when read at a negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Wait until the negedge that follows rising edge number n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] last_good       = 8'h00;
  int         err_seen        = 0;
  int         exp_err         = 0;
  int         last_status_cyc = -1;

  always @(negedge clk) begin
    logic [7:0] exp;
    if (!reset) begin
      if (bus.RX_STATUS || bus.RX_ERR)
        check("strobe_exclusive", {31'd0, bus.RX_STATUS & bus.RX_ERR}, 32'd0);
      if (bus.RX_STATUS) begin
        last_status_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", bus.RX_DATA);
        end else begin
          exp = exp_q.pop_front();
          check("rx_data", {24'd0, bus.RX_DATA}, {24'd0, exp});
          last_good = exp;
        end
      end
      if (bus.RX_ERR) begin
        err_seen++;
        check("data_held_on_err", {24'd0, bus.RX_DATA}, {24'd0, last_good});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_bits(input logic v, input int n, input int bit_ns);
    bus.UART_RX = v;
    #(n * bit_ns);
  endtask

  // One 8N1 frame; spike_bit >= 0 inverts the line for one clk early in
  // that data bit, well before the mid-bit vote window.
  task automatic send_frame(input logic [7:0] d, input int bit_ns,
                            input logic stop_v, input int spike_bit);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i - 1 == spike_bit) begin
        bus.UART_RX = bits[i];
        #20;
        bus.UART_RX = ~bits[i];
        #10;
        bus.UART_RX = bits[i];
        #(bit_ns - 30);
      end else begin
        bus.UART_RX = bits[i];
        #(bit_ns);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         bit_ns;
    logic       stop_v;
    int         spike_bit;
    int         lead_bits;   // idle-high bits before the frame
    logic       tail_v;
    int         tail_bits;   // bits held at tail_v after the frame
    logic       exp_ok;      // 1: byte expected, 0: framing error expected
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] d, input int bit_ns, input logic stop_v,
                         input int spike_bit, input int lead_bits, input logic tail_v,
                         input int tail_bits, input logic exp_ok);
    vec_t v;
    v.data = d; v.bit_ns = bit_ns; v.stop_v = stop_v; v.spike_bit = spike_bit;
    v.lead_bits = lead_bits; v.tail_v = tail_v; v.tail_bits = tail_bits; v.exp_ok = exp_ok;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int e0;

    // back-to-back bytes, no idle gap
    add_vec(8'h00, BIT_NS, 1'b1, -1, 2, 1'b1, 0, 1'b1);
    add_vec(8'hFF, BIT_NS, 1'b1, -1, 0, 1'b1, 0, 1'b1);
    add_vec(8'h55, BIT_NS, 1'b1, -1, 0, 1'b1, 2, 1'b1);
    // framing error followed by a 40-bit break, then recovery
    add_vec(8'h3C, BIT_NS, 1'b0, -1, 0, 1'b0, 40, 1'b0);
    add_vec(8'h12, BIT_NS, 1'b1, -1, 2, 1'b1, 2, 1'b1);
    // single-cycle spikes outside the vote window
    add_vec(8'hC3, BIT_NS, 1'b1, 3, 0, 1'b1, 2, 1'b1);
    add_vec(8'h5A, BIT_NS, 1'b1, 6, 0, 1'b1, 2, 1'b1);
    // baud skew: 10 frames each at 15.5 and 16.5 clk/bit, back to back
    for (int i = 0; i < 10; i++) add_vec(8'h96, 155, 1'b1, -1, 0, 1'b1, (i == 9) ? 2 : 0, 1'b1);
    for (int i = 0; i < 10; i++) add_vec(8'h96, 165, 1'b1, -1, 0, 1'b1, (i == 9) ? 2 : 0, 1'b1);

    // reset state
    bus.UART_RX = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'd0, bus.RX_DATA}, 32'h0);
    check("reset_status", {31'd0, bus.RX_STATUS}, 32'd0);
    check("reset_err", {31'd0, bus.RX_ERR}, 32'd0);
    check("reset_busy", {31'd0, bus.RX_BUSY}, 32'd0);
    check("reset_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single byte 0xA5: latency and busy envelope
    #1;
    e0 = cyc + 1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, BIT_NS, 1'b1, -1);
    join_none
    wait_cyc(e0 + 1);
    check("a5_busy_before_start", {31'd0, bus.RX_BUSY}, 32'd0);
    wait_cyc(e0 + 2);
    check("a5_busy_rise", {31'd0, bus.RX_BUSY}, 32'd1);
    check("a5_state_start", {30'd0, bus.state}, {30'd0, ST_START});
    wait_cyc(e0 + 155);
    check("a5_busy_late", {31'd0, bus.RX_BUSY}, 32'd1);
    check("a5_status_early", {31'd0, bus.RX_STATUS}, 32'd0);
    wait_cyc(e0 + 156);
    check("a5_status_pulse", {31'd0, bus.RX_STATUS}, 32'd1);
    check("a5_busy_fall", {31'd0, bus.RX_BUSY}, 32'd0);
    wait_cyc(e0 + 157);
    check("a5_status_one_cycle", {31'd0, bus.RX_STATUS}, 32'd0);
    wait_cyc(e0 + 165);
    check("a5_latency", last_status_cyc, e0 + 156);

    // table-driven frames
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp_ok) exp_q.push_back(vecs[i].data);
      else exp_err++;
      if (vecs[i].lead_bits > 0) drive_bits(1'b1, vecs[i].lead_bits, vecs[i].bit_ns);
      send_frame(vecs[i].data, vecs[i].bit_ns, vecs[i].stop_v, vecs[i].spike_bit);
      if (vecs[i].tail_bits > 0) drive_bits(vecs[i].tail_v, vecs[i].tail_bits, vecs[i].bit_ns);
    end
    check("table_pending_bytes", exp_q.size(), 32'd0);
    check("table_err_count", err_seen, exp_err);

    // 5-cycle glitch on the idle line
    @(negedge clk);
    #1;
    e0 = cyc + 1;
    fork
      begin
        bus.UART_RX = 1'b0;
        #50;
        bus.UART_RX = 1'b1;
      end
    join_none
    wait_cyc(e0 + 1);
    check("glitch_busy_pre", {31'd0, bus.RX_BUSY}, 32'd0);
    wait_cyc(e0 + 2);
    check("glitch_busy_rise", {31'd0, bus.RX_BUSY}, 32'd1);
    wait_cyc(e0 + 17);
    check("glitch_busy_last", {31'd0, bus.RX_BUSY}, 32'd1);
    wait_cyc(e0 + 18);
    check("glitch_busy_fall", {31'd0, bus.RX_BUSY}, 32'd0);
    check("glitch_state_idle", {30'd0, bus.state}, {30'd0, ST_IDLE});
    wait_cyc(e0 + 40);

    // reset during bit 4 of 0x81
    @(negedge clk);
    #1;
    bus.UART_RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      bus.UART_RX = (8'h81 >> i) & 8'h01;
      #(BIT_NS);
    end
    bus.UART_RX = 1'b0;
    #(BIT_NS / 2);
    @(negedge clk);
    check("mid_busy_before_reset", {31'd0, bus.RX_BUSY}, 32'd1);
    reset = 1'b1;
    bus.UART_RX = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check("mid_rx_data", {24'd0, bus.RX_DATA}, 32'h0);
    check("mid_status", {31'd0, bus.RX_STATUS}, 32'd0);
    check("mid_err", {31'd0, bus.RX_ERR}, 32'd0);
    check("mid_busy", {31'd0, bus.RX_BUSY}, 32'd0);
    check("mid_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
    reset = 1'b0;
    repeat (3 * OS) @(negedge clk);
    check("mid_no_strobe_data", {24'd0, bus.RX_DATA}, 32'h0);

    // next byte after reset is received normally
    #1;
    exp_q.push_back(8'h7E);
    drive_bits(1'b1, 1, BIT_NS);
    send_frame(8'h7E, BIT_NS, 1'b1, -1);
    drive_bits(1'b1, 2, BIT_NS);
    @(negedge clk);
    check("after_reset_byte", {24'd0, bus.RX_DATA}, 32'h7E);
    check("final_pending_bytes", exp_q.size(), 32'd0);
    check("final_err_count", err_seen, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
